// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU instruction sequencer: state encoding,
// opcode map, one-hot ALU_op bit positions and IR field positions.
package alu_seq_pkg;

    typedef enum logic [3:0] {
        StIdle, StT0, StT1, StT2, StDec, StT3, StT4, StT5, StT6, StU3, StU4, StDone
    } state_e;

    typedef enum logic [1:0] {ClsBinary, ClsUnary, ClsMulDiv, ClsIllegal} opc_class_e;

    localparam int unsigned AluOpW = 13;

    localparam logic [4:0] OpcAdd  = 5'b00011;
    localparam logic [4:0] OpcSub  = 5'b00100;
    localparam logic [4:0] OpcShr  = 5'b00101;
    localparam logic [4:0] OpcShra = 5'b00110;
    localparam logic [4:0] OpcShl  = 5'b00111;
    localparam logic [4:0] OpcRor  = 5'b01000;
    localparam logic [4:0] OpcRol  = 5'b01001;
    localparam logic [4:0] OpcAnd  = 5'b01010;
    localparam logic [4:0] OpcOr   = 5'b01011;
    localparam logic [4:0] OpcMul  = 5'b01111;
    localparam logic [4:0] OpcDiv  = 5'b10000;
    localparam logic [4:0] OpcNeg  = 5'b10001;
    localparam logic [4:0] OpcNot  = 5'b10010;

    localparam int unsigned AluAdd  = 0;
    localparam int unsigned AluSub  = 1;
    localparam int unsigned AluShr  = 2;
    localparam int unsigned AluShra = 3;
    localparam int unsigned AluShl  = 4;
    localparam int unsigned AluRor  = 5;
    localparam int unsigned AluRol  = 6;
    localparam int unsigned AluAnd  = 7;
    localparam int unsigned AluOr   = 8;
    localparam int unsigned AluMul  = 9;
    localparam int unsigned AluDiv  = 10;
    localparam int unsigned AluNeg  = 11;
    localparam int unsigned AluNot  = 12;

    // MSB of each IR field; fields run downward from here
    localparam int unsigned OpcMsb = 31;
    localparam int unsigned RaMsb  = 26;
    localparam int unsigned RbMsb  = 22;
    localparam int unsigned RcMsb  = 18;

    function automatic opc_class_e opc_class(input logic [4:0] opc);
        case (opc)
            OpcAdd, OpcSub, OpcShr, OpcShra, OpcShl,
            OpcRor, OpcRol, OpcAnd, OpcOr:  return ClsBinary;
            OpcNeg, OpcNot:                 return ClsUnary;
            OpcMul, OpcDiv:                 return ClsMulDiv;
            default:                        return ClsIllegal;
        endcase
    endfunction

    function automatic logic [AluOpW-1:0] alu_op_onehot(input logic [4:0] opc);
        logic [AluOpW-1:0] oh;
        oh = '0;
        case (opc)
            OpcAdd:  oh[AluAdd]  = 1'b1;
            OpcSub:  oh[AluSub]  = 1'b1;
            OpcShr:  oh[AluShr]  = 1'b1;
            OpcShra: oh[AluShra] = 1'b1;
            OpcShl:  oh[AluShl]  = 1'b1;
            OpcRor:  oh[AluRor]  = 1'b1;
            OpcRol:  oh[AluRol]  = 1'b1;
            OpcAnd:  oh[AluAnd]  = 1'b1;
            OpcOr:   oh[AluOr]   = 1'b1;
            OpcMul:  oh[AluMul]  = 1'b1;
            OpcDiv:  oh[AluDiv]  = 1'b1;
            OpcNeg:  oh[AluNeg]  = 1'b1;
            OpcNot:  oh[AluNot]  = 1'b1;
            default: oh = '0;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/alu_instr_sequencer_if.sv
// Control/status bundle between the sequencer (master) and the DataPath side (slave).
interface alu_instr_sequencer_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS   = 16
);
    logic                  Run;
    logic                  Mem_ready;
    logic [DATA_WIDTH-1:0] IR;

    logic PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin;
    logic Yin, Zin, Zhighout, Zlowout, HIin, LOin;
    logic [NUM_REGS-1:0] R_in;
    logic [NUM_REGS-1:0] R_out;
    logic [12:0]         ALU_op;
    logic Busy, Done, Illegal;

    modport master (
        input  Run, Mem_ready, IR,
        output PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin,
        output Yin, Zin, Zhighout, Zlowout, HIin, LOin,
        output R_in, R_out, ALU_op, Busy, Done, Illegal
    );

    modport slave (
        output Run, Mem_ready, IR,
        input  PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin,
        input  Yin, Zin, Zhighout, Zlowout, HIin, LOin,
        input  R_in, R_out, ALU_op, Busy, Done, Illegal
    );
endinterface

// File: rtl/reg_field_decoder.sv
// Register field to one-hot select; fields at or above NUM_REGS decode to all-zero
// and raise oor_o.
module reg_field_decoder #(
    parameter int unsigned REG_FIELD_W = 4,
    parameter int unsigned NUM_REGS    = 16
) (
    input  logic [REG_FIELD_W-1:0] field_i,
    output logic [NUM_REGS-1:0]    onehot_o,
    output logic                   oor_o
);

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_onehot
        assign onehot_o[g] = (32'(field_i) == g);
    end

    assign oor_o = (32'(field_i) >= NUM_REGS);

endmodule

// File: rtl/alu_instr_sequencer.sv
// Hardwired fetch/decode/execute controller for the DataPath register-register ALU ops.
// Optional SEQ_AUTO_FETCH_EN: DONE chains straight into the next fetch while Run is high.
module alu_instr_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned NUM_REGS    = 16,
    parameter int unsigned REG_FIELD_W = 4,
    parameter int unsigned OPC_W       = 5
) (
    input  logic                  Clock,
    input  logic                  Clear,
    alu_instr_sequencer_if.master bus
);

    state_e state_q, state_d;
    logic [OPC_W-1:0]       opc_q, opc_d;
    logic [REG_FIELD_W-1:0] ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;
    logic                   illegal_q, illegal_d;

    logic [NUM_REGS-1:0] ra_oh, rb_oh, rc_oh;
    logic                ra_oor, rb_oor, rc_oor;
    opc_class_e          cls;
    logic                muldiv;
    logic [AluOpW-1:0]   alu_oh;
    logic                unused_ir;

    assign cls       = opc_class(opc_q);
    assign muldiv    = (cls == ClsMulDiv);
    assign alu_oh    = alu_op_onehot(opc_q);
    assign unused_ir = ^bus.IR[RcMsb-REG_FIELD_W:0];

    reg_field_decoder #(.REG_FIELD_W(REG_FIELD_W), .NUM_REGS(NUM_REGS)) u_dec_ra (
        .field_i (ra_q),
        .onehot_o(ra_oh),
        .oor_o   (ra_oor)
    );

    reg_field_decoder #(.REG_FIELD_W(REG_FIELD_W), .NUM_REGS(NUM_REGS)) u_dec_rb (
        .field_i (rb_q),
        .onehot_o(rb_oh),
        .oor_o   (rb_oor)
    );

    reg_field_decoder #(.REG_FIELD_W(REG_FIELD_W), .NUM_REGS(NUM_REGS)) u_dec_rc (
        .field_i (rc_q),
        .onehot_o(rc_oh),
        .oor_o   (rc_oor)
    );

    always_ff @(posedge Clock) begin
        if (Clear) begin
            state_q   <= StIdle;
            opc_q     <= '0;
            ra_q      <= '0;
            rb_q      <= '0;
            rc_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            opc_q     <= opc_d;
            ra_q      <= ra_d;
            rb_q      <= rb_d;
            rc_q      <= rc_d;
            illegal_q <= illegal_d;
        end
    end

    // Fields captured once on leaving T2; later IR changes cannot disturb execution
    always_comb begin
        opc_d = opc_q;
        ra_d  = ra_q;
        rb_d  = rb_q;
        rc_d  = rc_q;
        if (state_q == StT2) begin
            opc_d = bus.IR[OpcMsb -: OPC_W];
            ra_d  = bus.IR[RaMsb -: REG_FIELD_W];
            rb_d  = bus.IR[RbMsb -: REG_FIELD_W];
            rc_d  = bus.IR[RcMsb -: REG_FIELD_W];
        end
    end

    // Only the fields an op actually uses can flag an out-of-range register
    always_comb begin
        illegal_d = illegal_q;
        if (state_q == StDec) begin
            unique case (cls)
                ClsBinary:  illegal_d = illegal_q | ra_oor | rb_oor | rc_oor;
                ClsUnary:   illegal_d = illegal_q | ra_oor | rb_oor;
                ClsMulDiv:  illegal_d = illegal_q | rb_oor | rc_oor;
                ClsIllegal: illegal_d = 1'b1;
                default:    illegal_d = illegal_q;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (bus.Run) state_d = StT0;
            StT0:   state_d = StT1;
            StT1:   if (bus.Mem_ready) state_d = StT2;
            StT2:   state_d = StDec;
            StDec: begin
                unique case (cls)
                    ClsBinary, ClsMulDiv: state_d = StT3;
                    ClsUnary:             state_d = StU3;
                    default:              state_d = StDone;
                endcase
            end
            StT3:   state_d = StT4;
            StT4:   state_d = StT5;
            StT5:   state_d = muldiv ? StT6 : StDone;
            StT6:   state_d = StDone;
            StU3:   state_d = StU4;
            StU4:   state_d = StDone;
`ifdef SEQ_AUTO_FETCH_EN
            StDone: state_d = bus.Run ? StT0 : StIdle;
`else
            StDone: state_d = StIdle;
`endif
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.PCout    = 1'b0;
        bus.MARin    = 1'b0;
        bus.IncPC    = 1'b0;
        bus.PCin     = 1'b0;
        bus.Read     = 1'b0;
        bus.MDRin    = 1'b0;
        bus.MDRout   = 1'b0;
        bus.IRin     = 1'b0;
        bus.Yin      = 1'b0;
        bus.Zin      = 1'b0;
        bus.Zhighout = 1'b0;
        bus.Zlowout  = 1'b0;
        bus.HIin     = 1'b0;
        bus.LOin     = 1'b0;
        bus.R_in     = '0;
        bus.R_out    = '0;
        bus.ALU_op   = '0;
        bus.Done     = 1'b0;
        unique case (state_q)
            StT0: begin
                bus.PCout = 1'b1;
                bus.MARin = 1'b1;
                bus.IncPC = 1'b1;
                bus.Zin   = 1'b1;
            end
            StT1: begin
                bus.Zlowout = 1'b1;
                bus.PCin    = 1'b1;
                bus.Read    = 1'b1;
                bus.MDRin   = 1'b1;
            end
            StT2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
            end
            StT3: begin
                bus.R_out = rb_oh;
                bus.Yin   = 1'b1;
            end
            StT4: begin
                bus.R_out  = rc_oh;
                bus.ALU_op = alu_oh;
                bus.Zin    = 1'b1;
            end
            StT5: begin
                bus.Zlowout = 1'b1;
                if (muldiv) bus.LOin = 1'b1;
                else        bus.R_in = ra_oh;
            end
            StT6: begin
                bus.Zhighout = 1'b1;
                bus.HIin     = 1'b1;
            end
            StU3: begin
                bus.R_out  = rb_oh;
                bus.ALU_op = alu_oh;
                bus.Zin    = 1'b1;
            end
            StU4: begin
                bus.Zlowout = 1'b1;
                bus.R_in    = ra_oh;
            end
            StDone:  bus.Done = 1'b1;
            default: ;
        endcase
        bus.Busy    = (state_q != StIdle);
        bus.Illegal = illegal_q;
    end

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Directed bench: a small DataPath/memory model driven by the sequencer's control pins,
// with hand-computed results and cycle counts.
module tb_alu_instr_sequencer;

    logic clk;
    logic clear;

    alu_instr_sequencer_if #(.DATA_WIDTH(32), .NUM_REGS(16)) bus_if ();

    alu_instr_sequencer #(
        .DATA_WIDTH (32),
        .NUM_REGS   (16),
        .REG_FIELD_W(4),
        .OPC_W      (5)
    ) dut (
        .Clock(clk),
        .Clear(clear),
        .bus  (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    function automatic logic [31:0] enc(input logic [4:0] opc, input logic [3:0] ra,
                                        input logic [3:0] rb, input logic [3:0] rc);
        return {opc, ra, rb, rc, 15'd0};
    endfunction

    // ---------------- DataPath model ----------------
    logic [31:0] rf [16];
    logic [31:0] mem [16];
    logic [31:0] pc, mar, mdr, ir_m, y, hi, lo;
    logic [63:0] z;
    logic [31:0] bus_v;
    int          n_drv;
    int          bus_err = 0;
    logic        pl_en;
    logic [3:0]  pl_idx;
    logic [31:0] pl_val;

    function automatic logic [63:0] alu_f(input logic [12:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [4:0] s;
        s = b[4:0];
        if (op[0])  return {32'd0, a + b};
        if (op[1])  return {32'd0, a - b};
        if (op[2])  return {32'd0, a >> s};
        if (op[3])  return {32'd0, $signed(a) >>> s};
        if (op[4])  return {32'd0, a << s};
        if (op[5])  return {32'd0, (a >> s) | (a << (6'd32 - {1'b0, s}))};
        if (op[6])  return {32'd0, (a << s) | (a >> (6'd32 - {1'b0, s}))};
        if (op[7])  return {32'd0, a & b};
        if (op[8])  return {32'd0, a | b};
        if (op[9])  return 64'(a) * 64'(b);
        if (op[10]) return (b == 0) ? 64'd0 : {a % b, a / b};
        if (op[11]) return {32'd0, -b};
        if (op[12]) return {32'd0, ~b};
        return 64'd0;
    endfunction

    always_comb begin
        bus_v = '0;
        n_drv = 0;
        if (bus_if.PCout)    begin bus_v = pc;        n_drv = n_drv + 1; end
        if (bus_if.Zlowout)  begin bus_v = z[31:0];   n_drv = n_drv + 1; end
        if (bus_if.Zhighout) begin bus_v = z[63:32];  n_drv = n_drv + 1; end
        if (bus_if.MDRout)   begin bus_v = mdr;       n_drv = n_drv + 1; end
        for (int i = 0; i < 16; i++) begin
            if (bus_if.R_out[i]) begin bus_v = rf[i]; n_drv = n_drv + 1; end
        end
    end

    always @(posedge clk) begin
        if (clear) pc <= '0;
        else if (bus_if.PCin) pc <= bus_v;
        if (pl_en) rf[pl_idx] <= pl_val;
        for (int i = 0; i < 16; i++) if (bus_if.R_in[i]) rf[i] <= bus_v;
        if (bus_if.MARin) mar <= bus_v;
        if (bus_if.MDRin && bus_if.Read && bus_if.Mem_ready) mdr <= mem[mar[3:0]];
        if (bus_if.IRin) ir_m <= bus_v;
        if (bus_if.Yin)  y <= bus_v;
        if (bus_if.HIin) hi <= bus_v;
        if (bus_if.LOin) lo <= bus_v;
        if (bus_if.Zin) z <= bus_if.IncPC ? {32'd0, bus_v + 32'd1} : alu_f(bus_if.ALU_op, y, bus_v);
        if (n_drv > 1 || $countones(bus_if.R_in) > 1 || $countones(bus_if.R_out) > 1)
            bus_err <= bus_err + 1;
    end

    logic [61:0] outs;
    assign outs = {bus_if.PCout, bus_if.MARin, bus_if.IncPC, bus_if.PCin, bus_if.Read,
                   bus_if.MDRin, bus_if.MDRout, bus_if.IRin, bus_if.Yin, bus_if.Zin,
                   bus_if.Zhighout, bus_if.Zlowout, bus_if.HIin, bus_if.LOin, bus_if.R_in,
                   bus_if.R_out, bus_if.ALU_op, bus_if.Busy, bus_if.Done, bus_if.Illegal};

    // ---------------- stimulus helpers ----------------
    int cyc, alu_cyc, alu_cnt, rin_cyc, rin_cnt, hi_cyc, t1_cnt;
    bit done_seen;

    task automatic set_reg(input logic [3:0] idx, input logic [31:0] val);
        @(negedge clk);
        pl_en = 1'b1; pl_idx = idx; pl_val = val;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    // cyc counts rising edges since Run was raised; outputs sampled 1 time unit after each edge
    task automatic run_instr(input logic [31:0] instr, input int stall, input int abort_at,
                             input bit glitch, input bit hold_run);
        int stall_left;
        mem[pc[3:0]] = instr;
        @(negedge clk);
        bus_if.IR  = instr;
        bus_if.Run = 1'b1;
        cyc = 0; alu_cyc = 0; alu_cnt = 0; rin_cyc = 0; rin_cnt = 0; hi_cyc = 0; t1_cnt = 0;
        done_seen  = 1'b0;
        stall_left = stall;
        while (!done_seen && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            if (!hold_run) bus_if.Run = 1'b0;
            if (bus_if.ALU_op != 0) begin alu_cnt++; alu_cyc = cyc; end
            if (bus_if.R_in != 0)   begin rin_cnt++; rin_cyc = cyc; end
            if (bus_if.Zhighout && bus_if.HIin) hi_cyc = cyc;
            if (bus_if.Read) begin
                t1_cnt++;
                if (stall_left > 0) begin bus_if.Mem_ready = 1'b0; stall_left--; end
                else bus_if.Mem_ready = 1'b1;
            end
            if (glitch && cyc == 5) bus_if.IR = 32'hFFFF_FFFF;
            if (bus_if.Done) done_seen = 1'b1;
            if (abort_at != 0 && cyc == abort_at) begin
                clear = 1'b1;
                @(posedge clk); #1;
                clear = 1'b0;
                check("abort_outputs_zero", 64'(outs), 64'd0);
                break;
            end
        end
        if (hold_run) begin
            @(posedge clk); #1;
            check("idle_after_done_run_held", 64'(bus_if.Busy), 64'd0);
        end
        bus_if.Run       = 1'b0;
        bus_if.Mem_ready = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] pc_before;
        logic [31:0] instr;
        clear = 1'b1;
        pl_en = 1'b0; pl_idx = '0; pl_val = '0;
        bus_if.Run = 1'b0; bus_if.Mem_ready = 1'b1; bus_if.IR = '0;
        repeat (2) @(posedge clk);
        #1 clear = 1'b0;
        check("reset_outputs", 64'(outs), 64'd0);

        set_reg(2, 32'h25);      set_reg(3, 32'h14);
        set_reg(4, 32'h1_0000);  set_reg(5, 32'h1_0000);
        set_reg(6, 32'h0000_FFFF);
        set_reg(9, 32'd3);       set_reg(10, 32'd4);
        set_reg(11, 32'd100);    set_reg(12, 32'd7);

        // sub R1,R2,R3
        run_instr(32'h2091_8000, 0, 0, 1'b0, 1'b0);
        check("sub_done_cycle", 64'(cyc), 64'd8);
        check("sub_result", 64'(rf[1]), 64'h11);
        check("sub_aluop_cycles", 64'(alu_cnt), 64'd1);
        check("sub_aluop_in_t4", 64'(alu_cyc), 64'd6);
        check("sub_rin_in_t5", 64'(rin_cyc), 64'd7);
        check("sub_ir_loaded", 64'(ir_m), 64'h2091_8000);
        check("sub_not_illegal", 64'(bus_if.Illegal), 64'd0);

        // mul Rb=4, Rc=5
        run_instr(enc(5'b01111, 4'd0, 4'd4, 4'd5), 0, 0, 1'b0, 1'b0);
        check("mul_done_cycle", 64'(cyc), 64'd9);
        check("mul_lo", 64'(lo), 64'h0);
        check("mul_hi", 64'(hi), 64'h1);
        check("mul_t6_hiin", 64'(hi_cyc), 64'd8);
        check("mul_no_rin", 64'(rin_cnt), 64'd0);

        // div 100/7
        run_instr(enc(5'b10000, 4'd0, 4'd11, 4'd12), 0, 0, 1'b0, 1'b0);
        check("div_lo", 64'(lo), 64'd14);
        check("div_hi", 64'(hi), 64'd2);

        // not R7,R6
        run_instr(enc(5'b10010, 4'd7, 4'd6, 4'd0), 0, 0, 1'b0, 1'b0);
        check("not_done_cycle", 64'(cyc), 64'd7);
        check("not_result", 64'(rf[7]), 64'hFFFF_0000);
        check("not_rin_count", 64'(rin_cnt), 64'd1);
        check("not_rin_in_u4", 64'(rin_cyc), 64'd6);

        // neg R13,R12
        run_instr(enc(5'b10001, 4'd13, 4'd12, 4'd0), 0, 0, 1'b0, 1'b0);
        check("neg_result", 64'(rf[13]), 64'hFFFF_FFF9);

        // add R8,R9,R10 with three stalled T1 cycles
        pc_before = pc;
        instr     = enc(5'b00011, 4'd8, 4'd9, 4'd10);
        run_instr(instr, 3, 0, 1'b0, 1'b0);
        check("stall_done_cycle", 64'(cyc), 64'd11);
        check("stall_t1_cycles", 64'(t1_cnt), 64'd4);
        check("stall_result", 64'(rf[8]), 64'd7);
        check("stall_pc_once", 64'(pc), 64'(pc_before + 32'd1));
        check("stall_ir_loaded", 64'(ir_m), 64'(instr));

        // IR pin changes in T3; latched fields must win
        run_instr(enc(5'b00011, 4'd14, 4'd9, 4'd10), 0, 0, 1'b1, 1'b0);
        check("ir_change_ignored", 64'(rf[14]), 64'd7);

`ifdef SEQ_AUTO_FETCH_EN
        begin
            int n_done;
            mem[pc[3:0]]                = enc(5'b00011, 4'd15, 4'd9, 4'd10);
            mem[4'(pc[3:0] + 4'd1)]     = enc(5'b00011, 4'd0, 4'd9, 4'd9);
            @(negedge clk);
            bus_if.IR  = enc(5'b00011, 4'd15, 4'd9, 4'd10);
            bus_if.Run = 1'b1;
            cyc = 0; n_done = 0;
            while (n_done < 2 && cyc < 60) begin
                @(posedge clk); #1;
                cyc++;
                if (bus_if.Done) begin
                    n_done++;
                    if (n_done == 1) begin
                        bus_if.IR = enc(5'b00011, 4'd0, 4'd9, 4'd9);
                        @(posedge clk); #1;
                        cyc++;
                        check("auto_t0_after_done", 64'({bus_if.PCout, bus_if.Busy}), 64'd3);
                    end
                end
            end
            bus_if.Run = 1'b0;
            @(negedge clk);
            check("auto_second_done_cycle", 64'(cyc), 64'd16);
            check("auto_first_result", 64'(rf[15]), 64'd7);
            check("auto_second_result", 64'(rf[0]), 64'd6);
        end
`else
        // shl R15,R9,R10 with Run held high throughout
        run_instr(enc(5'b00111, 4'd15, 4'd9, 4'd10), 0, 0, 1'b0, 1'b1);
        check("held_run_done_cycle", 64'(cyc), 64'd8);
        check("shl_result", 64'(rf[15]), 64'h30);
`endif

        // unknown opcode
        run_instr(enc(5'b11111, 4'd1, 4'd2, 4'd3), 0, 0, 1'b0, 1'b0);
        check("illegal_done_cycle", 64'(cyc), 64'd5);
        check("illegal_flag", 64'(bus_if.Illegal), 64'd1);
        check("illegal_no_rin", 64'(rin_cnt), 64'd0);
        check("illegal_r1_kept", 64'(rf[1]), 64'h11);
        run_instr(enc(5'b00011, 4'd1, 4'd9, 4'd10), 0, 0, 1'b0, 1'b0);
        check("illegal_sticky", 64'(bus_if.Illegal), 64'd1);
        pulse_clear();
        check("illegal_cleared", 64'(bus_if.Illegal), 64'd0);

        // Clear while in T4 of add R2,R9,R10
        run_instr(enc(5'b00011, 4'd2, 4'd9, 4'd10), 0, 6, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check("abort_no_write", 64'(rf[2]), 64'h25);
        check("abort_idle", 64'(bus_if.Busy), 64'd0);

        check("bus_single_driver", 64'(bus_err), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_instr_sequencer.md
Name: alu_instr_sequencer

Overview:
- Hardwired control unit for the DataPath. Replaces the hand-stepped control sequences used in bench bring-up.
- Fetches one instruction: PC to MAR, PC+1, memory read, MDR to IR.
- Decodes the opcode and Ra/Rb/Rc fields, then drives register-select and ALU control for every register-register ALU instruction.
- Covers binary, unary and HI/LO-producing (MUL/DIV) ops; sits beside DataPath and feeds its control pins directly.

Parameters:
- DATA_WIDTH, 32, instruction/IR width.
- NUM_REGS, 16, general registers; sets the width of the one-hot R_in/R_out vectors.
- REG_FIELD_W, 4, bits per register field; must satisfy 2**REG_FIELD_W >= NUM_REGS.
- OPC_W, 5, opcode field width.

Ports:
- Clock  in  1  rising-edge clock.
- Clear  in  1  synchronous, active-high reset.
- Run  in  1  start a fetch/execute when idle.
- Mem_ready  in  1  memory read data valid.
- IR  in  DATA_WIDTH  current IR contents from DataPath.
- PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin  out  1 each  fetch-phase controls.
- Yin, Zin, Zhighout, Zlowout, HIin, LOin  out  1 each  execute-phase controls.
- R_in  out  NUM_REGS  one-hot register load.
- R_out  out  NUM_REGS  one-hot register drive.
- ALU_op  out  13  one-hot, bit order ADD,SUB,SHR,SHRA,SHL,ROR,ROL,AND,OR,MUL,DIV,NEG,NOT.
- Busy  out  1  high in any state other than IDLE.
- Done  out  1  one-cycle pulse on instruction completion.
- Illegal  out  1  sticky flag for an unknown opcode; cleared only by Clear.

Behaviour:
- Reset:
  - Clear high at a rising edge forces state to IDLE and clears Illegal.
  - All outputs are 0 the following cycle.
  - Clear mid-instruction aborts immediately; no partial register write is issued after the Clear edge.
- Output timing: all outputs are Moore, decoded from the registered state plus registered IR fields. Exactly one state per clock.
- IR field positions: opcode IR[31:27], Ra IR[26:23], Rb IR[22:19], Rc IR[18:15].
- Field latching: fields are latched at the exit of T2, so IR changes during T3+ are ignored.
- State IDLE: Run=1 goes to T0.
- State T0: PCout, MARin, IncPC, Zin; then T1.
- State T1: Zlowout, PCin, Read, MDRin.
  - Hold in T1 while Mem_ready=0; outputs stay asserted (the PC reload is idempotent).
  - Go to T2 on the cycle Mem_ready=1.
- State T2: MDRout, IRin; then DEC.
- State DEC (no outputs): classify the latched opcode.
  - Binary op: go to T3.
  - NEG/NOT: go to U3.
  - MUL/DIV: go to T3.
  - Unknown opcode: set Illegal, go to DONE with no register write.
- State T3: R_out[Rb], Yin.
- State T4: R_out[Rc], ALU_op bit, Zin.
- State T5, normal ops: Zlowout, R_in[Ra]; then DONE.
- State T5, MUL/DIV: Zlowout, LOin; then T6.
- State T6 (MUL/DIV only): Zhighout, HIin; then DONE.
- State U3: R_out[Rb], ALU_op bit, Zin; then U4.
- State U4: Zlowout, R_in[Ra]; then DONE.
- State DONE: Done=1 for one cycle; then IDLE.
- Out-of-range register fields: a field >= NUM_REGS drives all-zero R_in/R_out and sets Illegal; the sequence still completes.
- Run while Busy is ignored.
- Invariant: R_in and R_out are each at most one-hot in every cycle; there is never more than one bus driver.
- Latency with Mem_ready tied high: binary op 8 cycles Run->Done; MUL/DIV 9; unary 7.

Optional Feature:
- Macro: SEQ_AUTO_FETCH_EN.
- Defined: DONE goes directly to T0 (continuous execution) while Run=1. Run=0 at DONE returns to IDLE.
- Undefined: DONE always returns to IDLE; each instruction needs a fresh Run.

Decomposition:
- Package alu_seq_pkg: state enum, opcode constants (ADD 00011, SUB 00100, SHR 00101, SHRA 00110, SHL 00111, ROR 01000, ROL 01001, AND 01010, OR 01011, MUL 01111, DIV 10000, NEG 10001, NOT 10010), ALU_op bit indices, field bit positions.
- One sub-module, reg_field_decoder: maps REG_FIELD_W to a one-hot NUM_REGS vector plus an out-of-range flag. It is instantiated three times.

Test Plan:
- SUB: R2=0x25, R3=0x14, IR=0x20918000 (sub R1,R2,R3), Mem_ready tied 1 -> R1=0x11; Done at cycle 8; ALU_op SUB bit high only in T4.
- MUL: R4=0x10000, R5=0x10000, mul opcode with Rb=4, Rc=5 -> LO=0x0, HI=0x1; T6 asserts Zhighout+HIin; Done at cycle 9.
- NOT: R6=0x0000FFFF, IR not R7,R6 -> R7=0xFFFF0000; R_in never asserted outside U4.
- Memory stall: Mem_ready low for 3 cycles in T1 -> controller holds T1 for 4 cycles; IR loads the correct word; PC incremented exactly once.
- Illegal/abort: opcode 11111 -> Illegal=1, Done pulses, no R_in asserted. Separately, Clear asserted in T4 -> all outputs 0 next cycle, no R_in write.
- With SEQ_AUTO_FETCH_EN and Run held 1: two back-to-back ADDs -> second T0 immediately follows DONE; both results correct.
